// File: rtl/ad5660_pkg.sv
// ============================================================================
// Module  : ad5660_pkg
// Brief   : Shared constants and types for the AD5660 SPI frame receiver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ad5660_pkg;

  localparam int AD5660_BITS = 24;
  // Only word[17:0] is ever consumed; higher bits are shifted out and dropped.
  localparam int AD5660_KEEP = 18;

  typedef enum logic [1:0] {
    PD_NORMAL   = 2'b00,
    PD_1K       = 2'b01,
    PD_100K     = 2'b10,
    PD_TRISTATE = 2'b11
  } pd_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    WAIT_HIGH = 2'd2
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/ad5660_spi_rx_sync_edge.sv
// ============================================================================
// Module  : sync_edge
// Brief   : Multi-flop synchroniser (resets high) with rise/fall detection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '1;
      prev  <= 1'b1;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign rise = ~prev &  chain[STAGES-1];
  assign fall =  prev & ~chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/ad5660_spi_rx.sv
// ============================================================================
// Module  : ad5660_spi_rx
// Brief   : Oversampled AD5660 SPI frame receiver; optional frame statistics
//           enabled by defining AD5660_SPI_RX_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ad5660_spi_rx
  import ad5660_pkg::*;
#(
  parameter int BITS        = AD5660_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        SDI,
  output logic [15:0] data,
  output pd_t         pd,
  output logic        valid,
  output logic        frame_err,
  output logic        busy
`ifdef AD5660_SPI_RX_STATS_EN
  ,
  output logic [15:0] good_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam int CNT_W = $clog2(BITS + 1);

  if (BITS < AD5660_KEEP) begin : g_bad_bits
    $error("ad5660_spi_rx: BITS must be >= 18");
  end
  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("ad5660_spi_rx: SYNC_STAGES must be >= 2");
  end

  logic ss_rise;
  logic ss_fall;
  logic sclk_fall;
  logic sclk_rise_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (SS_n),
    .rise    (ss_rise),
    .fall    (ss_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (SCLK),
    .rise    (sclk_rise_unused),
    .fall    (sclk_fall)
  );

  // SDI delay matches the SCLK synchroniser so a detected fall sees its own bit.
  logic [SYNC_STAGES-1:0] sdi_dly;
  logic                   sdi_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdi_dly <= '1;
    end else begin
      sdi_dly <= {sdi_dly[SYNC_STAGES-2:0], SDI};
    end
  end

  assign sdi_sync = sdi_dly[SYNC_STAGES-1];

  rx_state_t              state, state_nx;
  logic [CNT_W-1:0]       bit_cnt, bit_cnt_nx;
  logic [AD5660_KEEP-1:0] shift_reg, shift_nx;
  logic                   done, done_nx;
  logic                   err_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      shift_reg <= shift_nx;
      done      <= done_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift_reg;
    done_nx    = 1'b0;
    err_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nx   = SHIFT;
          bit_cnt_nx = '0;
          shift_nx   = '0;
        end
      end
      SHIFT: begin
        if (sclk_fall) begin
          shift_nx   = {shift_reg[AD5660_KEEP-2:0], sdi_sync};
          bit_cnt_nx = bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(BITS - 1)) begin
            done_nx  = 1'b1;
            state_nx = WAIT_HIGH;
          end
        end
        // A final edge coinciding with SS_n rising still completes the frame.
        if (ss_rise) begin
          state_nx = IDLE;
          err_nx   = ~done_nx;
        end
      end
      WAIT_HIGH: begin
        if (ss_rise) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Outputs lag the completing edge by one cycle so the shift register is final.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data      <= '0;
      pd        <= PD_NORMAL;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= done;
      frame_err <= err_nx;
      busy      <= (state_nx != IDLE);
      if (done) begin
        data <= shift_reg[15:0];
        pd   <= pd_t'(shift_reg[17:16]);
      end
    end
  end

`ifdef AD5660_SPI_RX_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      good_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (done) begin
        good_cnt <= good_cnt + 16'd1;
      end
      if (err_nx) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ad5660_spi_rx.sv
// ============================================================================
// Module  : tb_ad5660_spi_rx
// Brief   : Self-checking bench for ad5660_spi_rx (SCLK = clk/8, random frames).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ad5660_spi_rx;
  import ad5660_pkg::*;

  localparam int STAGES = 2;
  localparam int NBITS  = 24;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        SS_n;
  logic        SCLK;
  logic        SDI;
  logic [15:0] data;
  pd_t         pd;
  logic        valid;
  logic        frame_err;
  logic        busy;
`ifdef AD5660_SPI_RX_STATS_EN
  logic [15:0] good_cnt;
  logic [15:0] err_cnt;
`endif

  ad5660_spi_rx #(.BITS(NBITS), .SYNC_STAGES(STAGES)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .SDI       (SDI),
    .data      (data),
    .pd        (pd),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef AD5660_SPI_RX_STATS_EN
    ,
    .good_cnt  (good_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Monitor: pulse counts and captured words, sampled mid-cycle.
  int          cyc = 0;
  int          vcnt = 0;
  int          ecnt = 0;
  int          valid_cyc = 0;
  int          fall_cyc = 0;
  logic [15:0] vdata_q[$];
  logic [1:0]  vpd_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcnt      = vcnt + 1;
      valid_cyc = cyc;
      vdata_q.push_back(data);
      vpd_q.push_back(pd);
    end
    if (frame_err === 1'b1) ecnt = ecnt + 1;
  end

  // Reference state: what the outputs must hold after the frames sent so far.
  logic [15:0] exp_data = 16'h0;
  logic [1:0]  exp_pd   = 2'b00;

  task automatic send_frame(input logic [23:0] word, input int nedges,
                            input bit raise_ss, input int gap);
    SS_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nedges; i++) begin
      SDI = (i < 24) ? word[23-i] : 1'($urandom_range(1, 0));
      repeat (4) @(negedge clk);
      SCLK = 1'b0;
      if (i == NBITS - 1) fall_cyc = cyc;
      repeat (4) @(negedge clk);
      SCLK = 1'b1;
    end
    repeat (4) @(negedge clk);
    if (raise_ss) begin
      SS_n = 1'b1;
      repeat (gap) @(negedge clk);
    end
  endtask

  // Model of a complete frame: good iff at least NBITS falling edges seen.
  task automatic model_frame(input logic [23:0] word, input int nedges,
                             output int dv, output int de);
    if (nedges >= NBITS) begin
      exp_data = word[15:0];
      exp_pd   = word[17:16];
      dv = 1; de = 0;
    end else begin
      dv = 0; de = 1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; SDI = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (data !== 16'h0)   begin bad++; $display("FAIL reset_data got=%h want=0000", data); end
    total++; if (pd !== PD_NORMAL) begin bad++; $display("FAIL reset_pd got=%b want=00", pd); end
    total++; if (valid !== 1'b0)   begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", frame_err); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input string name, input logic [23:0] word, input int nedges,
                           input int gap);
    int v0, e0, dv, de;
    v0 = vcnt; e0 = ecnt;
    send_frame(word, nedges, 1'b1, gap);
    model_frame(word, nedges, dv, de);
    total++; if (vcnt - v0 !== dv) begin bad++; $display("FAIL %s valid_count got=%0d want=%0d", name, vcnt - v0, dv); end
    total++; if (ecnt - e0 !== de) begin bad++; $display("FAIL %s err_count got=%0d want=%0d", name, ecnt - e0, de); end
    total++; if (data !== exp_data) begin bad++; $display("FAIL %s data got=%h want=%h", name, data, exp_data); end
    total++; if (pd !== exp_pd)     begin bad++; $display("FAIL %s pd got=%b want=%b", name, pd, exp_pd); end
  endtask

  task automatic test_good_frame();
    run_frame("good", 24'h85ABCD, 24, 10);
    total++; if (valid_cyc - fall_cyc !== STAGES + 2) begin
      bad++; $display("FAIL latency got=%0d want=%0d", valid_cyc - fall_cyc, STAGES + 2);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_abort();
    run_frame("abort", 24'h00FFFF, 10, 10);
  endtask

  task automatic test_overclock();
    run_frame("overclock", 24'h030123, 30, 10);
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = vcnt;
    vdata_q.delete(); vpd_q.delete();
    send_frame(24'h001111, 24, 1'b1, 2);
    send_frame(24'h022222, 24, 1'b1, 10);
    exp_data = 16'h2222; exp_pd = 2'b10;
    total++; if (vcnt - v0 !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", vcnt - v0); end
    if (vdata_q.size() >= 2) begin
      total++; if (vdata_q[0] !== 16'h1111) begin bad++; $display("FAIL b2b_data0 got=%h want=1111", vdata_q[0]); end
      total++; if (vpd_q[0] !== 2'b00)      begin bad++; $display("FAIL b2b_pd0 got=%b want=00", vpd_q[0]); end
      total++; if (vdata_q[1] !== 16'h2222) begin bad++; $display("FAIL b2b_data1 got=%h want=2222", vdata_q[1]); end
      total++; if (vpd_q[1] !== 2'b10)      begin bad++; $display("FAIL b2b_pd1 got=%b want=10", vpd_q[1]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(24'($urandom), 12, 1'b0, 0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
    reset_n = 1'b0;
    #1;
    total++; if (data !== 16'h0) begin bad++; $display("FAIL rst_mid_data got=%h want=0000", data); end
    total++; if (pd !== PD_NORMAL) begin bad++; $display("FAIL rst_mid_pd got=%b want=00", pd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    SS_n = 1'b1; SCLK = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    exp_data = 16'h0; exp_pd = 2'b00;
    repeat (4) @(negedge clk);
    run_frame("after_reset", 24'h00BEEF, 24, 10);
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 10; k++) begin
      logic [23:0] w;
      int n;
      w = 24'($urandom);
      n = $urandom_range(30, 5);
      run_frame("random", w, n, $urandom_range(12, 2));
    end
  endtask

`ifdef AD5660_SPI_RX_STATS_EN
  task automatic test_stats();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_data = 16'h0; exp_pd = 2'b00;
    repeat (4) @(negedge clk);
    run_frame("st_g1", 24'($urandom), 24, 10);
    run_frame("st_a1", 24'($urandom), 7, 10);
    run_frame("st_g2", 24'($urandom), 26, 10);
    run_frame("st_a2", 24'($urandom), 20, 10);
    run_frame("st_g3", 24'($urandom), 24, 10);
    total++; if (good_cnt !== 16'd3) begin bad++; $display("FAIL good_cnt got=%0d want=3", good_cnt); end
    total++; if (err_cnt !== 16'd2)  begin bad++; $display("FAIL err_cnt got=%0d want=2", err_cnt); end
    force dut.good_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.good_cnt;
    run_frame("st_wrap", 24'($urandom), 24, 10);
    total++; if (good_cnt !== 16'd0) begin bad++; $display("FAIL good_cnt_wrap got=%0d want=0", good_cnt); end
  endtask
`endif

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_good_frame();
    test_abort();
    test_overclock();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_frames();
`ifdef AD5660_SPI_RX_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ad5660_spi_rx.md
Name: ad5660_spi_rx

Overview:
- Synthesizable SPI responder-side receiver for the AD5660 DAC frame format: SYNC-framed, MSB-first, sampled on the SCLK falling edge.
- Deserialises the 24-bit word and decodes the power-down bits and the 16-bit DAC code.
- Sits on the FPGA as a loopback checker for the DAC SPI transmitter and as a DAC model for board-level self-test.
- Oversamples all SPI pins with the system clock; there is no SCLK clock domain.

Parameters:
- BITS, 24, frame length in SCLK edges; must be ≥ 18.
- SYNC_STAGES, 2, synchroniser depth for SS_n, SCLK and SDI; must be ≥ 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- SS_n  in  1  frame select, active-low (DAC SYNC).
- SCLK  in  1  serial clock, idle high.
- SDI  in  1  serial data, MSB first.
- data  out  16  DAC code, word[15:0] of the last good frame.
- pd  out  2  power-down mode, word[17:16] of the last good frame.
- valid  out  1  one-cycle pulse when data/pd update.
- frame_err  out  1  one-cycle pulse on an aborted frame.
- busy  out  1  high while a frame is in progress (state ≠ IDLE).

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous, active-low.
- Reset values: data=0, pd=0, valid=0, frame_err=0, busy=0, state=IDLE, bit counter=0, shift register=0, synchroniser flops=1.
- Input sync: SS_n, SCLK and SDI pass through SYNC_STAGES flops. SDI is sampled from the same synchroniser stage as SCLK, so the two stay aligned.
- Edge detection:
  - SCLK falling edge (fall_sclk) = previous synced SCLK 1, current 0.
  - SS_n edges are detected the same way.
- Timing constraint: SCLK high and low times must each be ≥ 3 clk periods, and SDI must be stable around the falling edge. Faster SCLK is out of spec and behaviour is undefined.
- FSM states: IDLE, SHIFT, WAIT_HIGH.
- IDLE:
  - synced SS_n falling → SHIFT; clear counter and shift register.
  - SCLK edges are ignored.
- SHIFT:
  - on fall_sclk: shift register = {shift[BITS-2:0], SDI_sync}; counter++.
  - when the BITS-th fall_sclk is accepted → WAIT_HIGH. On the next cycle: data ← word[15:0], pd ← word[17:16], valid=1 for one cycle. word[BITS-1:18] is ignored.
  - SS_n rises with counter < BITS → IDLE, frame_err=1 for one cycle, data/pd unchanged.
- WAIT_HIGH:
  - further fall_sclk are ignored; no second valid is produced.
  - SS_n rising → IDLE; no error is flagged.
- Simultaneous events:
  - The BITS-th fall_sclk and SS_n rise in the same cycle count as a good frame (valid, no frame_err).
  - An SS_n fall while in WAIT_HIGH cannot occur, since SS_n must rise first.
- Latency: pin SCLK falling edge → valid is SYNC_STAGES+2 clk cycles.
- Back-to-back frames: an SS_n high gap ≥ 2 synced cycles is sufficient. A new SS_n fall is detected from IDLE.
- Reset mid-frame: everything returns to reset values immediately and the partial frame is discarded. Because the synchroniser resets to 1, an SS_n held low through reset release produces a falling edge and starts a fresh frame.
- busy: registered, equals (state ≠ IDLE).

Optional Feature:
- Macro: AD5660_SPI_RX_STATS_EN.
- Defined:
  - Adds output ports good_cnt[15:0] and err_cnt[15:0].
  - good_cnt increments on each valid; err_cnt increments on each frame_err.
  - Both wrap modulo 2^16 and reset to 0.
- Not defined: the ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package ad5660_pkg holds:
  - localparam AD5660_BITS = 24;
  - typedef enum logic [1:0] pd_t: PD_NORMAL=2'b00, PD_1K=2'b01, PD_100K=2'b10, PD_TRISTATE=2'b11;
  - typedef enum rx_state_t: IDLE, SHIFT, WAIT_HIGH.
- pd is typed pd_t.
- Sub-module sync_edge (parameter STAGES): synchroniser plus registered rise/fall detect. It is instantiated for SS_n and SCLK; SDI uses a plain delay line of matching depth.

Test Plan:
- Good frame: SS_n low, shift 24'h85ABCD at SCLK = clk/8, SS_n high → exactly one valid, data=16'hABCD, pd=PD_1K (2'b01), frame_err never asserted.
- Abort: frame 24'h00FFFF with SS_n raised after 10 falling edges → one frame_err, no valid, data/pd retain their previous values (16'hABCD, 2'b01).
- Overclock: 30 falling edges in one frame, first 24 bits = 24'h030123 → one valid, data=16'h0123, pd=PD_TRISTATE; edges 25–30 ignored.
- Back-to-back: frames 24'h001111 and 24'h022222 with a 2-clk SS_n gap → two valids, data=16'h1111 then 16'h2222, pd=00 then 10.
- Reset mid-frame: reset_n pulsed low after 12 edges → all outputs 0. A following 24'h00BEEF frame gives data=16'hBEEF, valid once.
- With AD5660_SPI_RX_STATS_EN: 3 good frames + 2 aborts → good_cnt=3, err_cnt=2. After forcing good_cnt to 16'hFFFF, the next good frame → good_cnt=0.
